// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : N-channel push-button front end: 2-flop synchroniser, counter
//            debounce, edge strobes. Optional auto-repeat: BTN_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_trig,
  output logic [WIDTH-1:0] btn_repeat
);

  localparam int                c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  // Unsupported EDGE_MODE values fall back to press-only.
  localparam int c_mode       = (EDGE_MODE == 1 || EDGE_MODE == 2) ? EDGE_MODE : 0;
  localparam bit c_pulse_rise = (c_mode != 1);
  localparam bit c_pulse_fall = (c_mode != 0);

`ifdef BTN_AUTOREPEAT_EN
  localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_rep_w   = $clog2(c_rep_max + 1);
  localparam logic [c_rep_w-1:0] c_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
  localparam logic [c_rep_w-1:0] c_period_last = c_rep_w'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic              r_sync1;
    logic              r_sync2;
    logic              r_stable;
    logic [c_db_w-1:0] r_db_cnt;
    logic              r_trig;
    logic              w_diff;
    logic              w_flip;
    logic              w_rise;
    logic              w_fall;
    logic              w_rep;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= btn[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_diff = r_sync2 ^ r_stable;
    assign w_flip = w_diff && (r_db_cnt == c_db_last);
    assign w_rise = w_flip && r_sync2;
    assign w_fall = w_flip && !r_sync2;

    // Any cycle where the synchronised input agrees with the stable level
    // restarts the count, so only an unbroken run can flip the level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_stable <= 1'b0;
        r_db_cnt <= '0;
      end else if (!w_diff) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    rep_state_t         r_state;
    rep_state_t         w_state_nxt;
    logic [c_rep_w-1:0] r_rep_cnt;
    logic [c_rep_w-1:0] w_rep_cnt_nxt;
    logic               r_repeat;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state   <= ST_IDLE;
        r_rep_cnt <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
      end
    end

    // A release always wins and suppresses any repeat strobe on that edge.
    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      w_rep         = 1'b0;
      if (w_fall) begin
        w_state_nxt   = ST_IDLE;
        w_rep_cnt_nxt = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise && c_pulse_rise) begin
              w_state_nxt   = ST_WAIT;
              w_rep_cnt_nxt = '0;
            end
          end
          ST_WAIT: begin
            if (r_rep_cnt == c_delay_last) begin
              w_rep         = 1'b1;
              w_rep_cnt_nxt = '0;
              w_state_nxt   = ST_REPEAT;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_rep_cnt == c_period_last) begin
              w_rep         = 1'b1;
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
          end
          default: begin
            w_state_nxt   = ST_IDLE;
            w_rep_cnt_nxt = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_repeat <= 1'b0;
      end else begin
        r_repeat <= w_rep;
      end
    end

    assign btn_repeat[g] = r_repeat;
`else
    assign w_rep         = 1'b0;
    assign btn_repeat[g] = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_trig <= 1'b0;
      end else begin
        r_trig <= (w_rise && c_pulse_rise) || (w_fall && c_pulse_fall) || w_rep;
      end
    end

    assign btn_level[g] = r_stable;
    assign btn_trig[g]  = r_trig;
  end

endmodule
`default_nettype wire
